reg_file_mp: RTL and testbench

- Parametrised multi-port successor to the single-write/dual-read datapath register file.
- Generalises width, depth, read-port and write-port counts.
- Adds optional hardwired-zero R0, same-cycle write-to-read bypass, priority resolution of colliding writes with a conflict flag, and a multi-cycle clear-sweep FSM.
- Sits between decode (addresses) and ALU/writeback (data) in the single-cycle core.

---
 rtl/reg_file_pkg.sv | 9 +
 rtl/rf_write_arbiter.sv | 45 ++++
 rtl/reg_file_mp.sv | 117 +++++++++++
 tb/tb_reg_file_mp.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Types and default sizes shared by the register file, decode and ALU.
package reg_file_pkg;

    typedef enum logic {IDLE, SWEEP} rf_state_t;

    localparam int RF_W = 8;
    localparam int RF_D = 3;

endpackage

// File: rtl/rf_write_arbiter.sv
// Resolves up to NW write ports into one write strobe and data word per register.
// When several ports hit the same register, the highest-indexed port wins and a collision is flagged.
module rf_write_arbiter
    import reg_file_pkg::*;
#(
    parameter int W       = RF_W,
    parameter int D       = RF_D,
    parameter int NW      = 2,
    parameter int ZERO_R0 = 0
) (
    input  logic                        i_busy,
    input  logic [NW-1:0]               i_write_en,
    input  logic [NW-1:0][D-1:0]        i_waddr,
    input  logic [NW-1:0][W-1:0]        i_data_in,
    output logic [2**D-1:0]             o_addr_we,
    output logic [2**D-1:0][W-1:0]      o_addr_wdata,
    output logic                        o_collision
);

    logic [NW-1:0] w_eff_en;

    always_comb begin
        w_eff_en     = '0;
        o_addr_we    = '0;
        o_addr_wdata = '0;
        o_collision  = 1'b0;
        for (int i = 0; i < NW; i++) begin
            w_eff_en[i] = i_write_en[i] && !i_busy
                          && !((ZERO_R0 != 0) && (i_waddr[i] == '0));
        end
        // Ascending port order, so the highest-indexed port's data is the one that sticks.
        for (int a = 0; a < 2**D; a++) begin
            for (int i = 0; i < NW; i++) begin
                if (w_eff_en[i] && (i_waddr[i] == D'(a))) begin
                    if (o_addr_we[a]) begin
                        o_collision = 1'b1;
                    end
                    o_addr_we[a]    = 1'b1;
                    o_addr_wdata[a] = i_data_in[i];
                end
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NW write ports, NR combinational read ports, optional zero R0,
// write-to-read bypass and a clear sweep that zeroes one register per cycle.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int W       = RF_W,
    parameter int D       = RF_D,
    parameter int NR      = 2,
    parameter int NW      = 2,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic                    CLK,
    input  logic                    init,
    input  logic [NW-1:0]           write_en,
    input  logic [NW-1:0][D-1:0]    waddr,
    input  logic [NW-1:0][W-1:0]    data_in,
    input  logic [NR-1:0][D-1:0]    raddr,
    output logic [NR-1:0][W-1:0]    data_out,
    input  logic                    clear_req,
    output logic                    busy,
    output logic                    wr_conflict
);

    localparam int DEPTH = 2**D;

    rf_state_t                  r_state;
    logic [D-1:0]               r_ptr;
    logic                       r_busy;
    logic                       r_conflict;
    logic [DEPTH-1:0][W-1:0]    r_regs;

    logic [DEPTH-1:0]           w_addr_we;
    logic [DEPTH-1:0][W-1:0]    w_addr_wdata;
    logic                       w_collision;

    rf_write_arbiter #(
        .W       (W),
        .D       (D),
        .NW      (NW),
        .ZERO_R0 (ZERO_R0)
    ) u_arb (
        .i_busy       (r_busy),
        .i_write_en   (write_en),
        .i_waddr      (waddr),
        .i_data_in    (data_in),
        .o_addr_we    (w_addr_we),
        .o_addr_wdata (w_addr_wdata),
        .o_collision  (w_collision)
    );

    // Sweep control: busy is registered so it tracks SWEEP exactly, one cycle after the request.
    always_ff @(posedge CLK) begin
        if (init) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_busy     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= w_collision;
            case (r_state)
                IDLE: begin
                    if (clear_req) begin
                        r_state <= SWEEP;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == D'(DEPTH - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (init) begin
            r_regs <= '0;
        end else if (r_state == SWEEP) begin
            r_regs[r_ptr] <= '0;
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (w_addr_we[a]) begin
                    r_regs[a] <= w_addr_wdata[a];
                end
            end
        end
    end

    always_comb begin
        data_out = '0;
        for (int j = 0; j < NR; j++) begin
            data_out[j] = r_regs[raddr[j]];
            if ((BYPASS != 0) && w_addr_we[raddr[j]]) begin
                data_out[j] = w_addr_wdata[raddr[j]];
            end
            if ((ZERO_R0 != 0) && (raddr[j] == '0)) begin
                data_out[j] = '0;
            end
            if (r_busy) begin
                data_out[j] = '0;
            end
        end
    end

    assign busy        = r_busy;
    assign wr_conflict = r_conflict;

endmodule

// File: tb/tb_reg_file_mp.sv
// Three register-file configurations run in lockstep against an array-based reference model;
// expected outputs are queued per cycle and compared by an independent negedge monitor.
module tb_reg_file_mp;

    localparam int NC = 3;
    localparam int          DEP [NC] = '{8, 8, 16};
    localparam int          NWC [NC] = '{2, 2, 1};
    localparam int          NRC [NC] = '{2, 2, 3};
    localparam int          ZRC [NC] = '{0, 1, 0};
    localparam int          BYC [NC] = '{1, 0, 1};
    localparam logic [15:0] MSK [NC] = '{16'h00FF, 16'h00FF, 16'hFFFF};

    logic CLK;
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // generic per-config stimulus
    logic        s_init [NC];
    logic        s_clr  [NC];
    logic        s_we   [NC][4];
    logic [3:0]  s_wa   [NC][4];
    logic [15:0] s_wd   [NC][4];
    logic [3:0]  s_ra   [NC][4];

    // reference model
    logic [15:0] m_regs  [NC][16];
    int          m_left  [NC];
    logic        m_conf  [NC];
    bit          m_valid [NC];

    typedef struct {
        int          cfg;
        int          kind;
        int          port;
        logic [15:0] exp;
    } sb_t;
    sb_t sb[$];

    int n_checks = 0;
    int n_err    = 0;

    // DUT signals
    logic [1:0]       we0, we1;
    logic [1:0][2:0]  wa0, wa1, ra0, ra1;
    logic [1:0][7:0]  wd0, wd1, do0, do1;
    logic             busy0, busy1, busy2, conf0, conf1, conf2;
    logic [0:0]       we2;
    logic [0:0][3:0]  wa2;
    logic [0:0][15:0] wd2;
    logic [2:0][3:0]  ra2;
    logic [2:0][15:0] do2;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            we0[i] = s_we[0][i];
            wa0[i] = s_wa[0][i][2:0];
            wd0[i] = s_wd[0][i][7:0];
            ra0[i] = s_ra[0][i][2:0];
            we1[i] = s_we[1][i];
            wa1[i] = s_wa[1][i][2:0];
            wd1[i] = s_wd[1][i][7:0];
            ra1[i] = s_ra[1][i][2:0];
        end
        we2[0] = s_we[2][0];
        wa2[0] = s_wa[2][0];
        wd2[0] = s_wd[2][0];
        for (int j = 0; j < 3; j++) ra2[j] = s_ra[2][j];
    end

    reg_file_mp #(.W(8), .D(3), .NR(2), .NW(2), .ZERO_R0(0), .BYPASS(1)) dut0 (
        .CLK(CLK), .init(s_init[0]), .write_en(we0), .waddr(wa0), .data_in(wd0),
        .raddr(ra0), .data_out(do0), .clear_req(s_clr[0]), .busy(busy0), .wr_conflict(conf0));

    reg_file_mp #(.W(8), .D(3), .NR(2), .NW(2), .ZERO_R0(1), .BYPASS(0)) dut1 (
        .CLK(CLK), .init(s_init[1]), .write_en(we1), .waddr(wa1), .data_in(wd1),
        .raddr(ra1), .data_out(do1), .clear_req(s_clr[1]), .busy(busy1), .wr_conflict(conf1));

    reg_file_mp #(.W(16), .D(4), .NR(3), .NW(1), .ZERO_R0(0), .BYPASS(1)) dut2 (
        .CLK(CLK), .init(s_init[2]), .write_en(we2), .waddr(wa2), .data_in(wd2),
        .raddr(ra2), .data_out(do2), .clear_req(s_clr[2]), .busy(busy2), .wr_conflict(conf2));

    function automatic string kind_name(int k);
        case (k)
            0:       return "data_out";
            1:       return "busy";
            default: return "wr_conflict";
        endcase
    endfunction

    function automatic logic [15:0] actual(int c, int k, int p);
        case (c)
            0: case (k)
                   0:       return {8'h00, do0[p]};
                   1:       return {15'b0, busy0};
                   default: return {15'b0, conf0};
               endcase
            1: case (k)
                   0:       return {8'h00, do1[p]};
                   1:       return {15'b0, busy1};
                   default: return {15'b0, conf1};
               endcase
            default: case (k)
                   0:       return do2[p];
                   1:       return {15'b0, busy2};
                   default: return {15'b0, conf2};
               endcase
        endcase
    endfunction

    function automatic bit eff(int c, int i);
        return s_we[c][i] && (m_left[c] == 0) && !((ZRC[c] != 0) && (s_wa[c][i] == 0));
    endfunction

    function automatic logic [15:0] exp_read(int c, int a);
        int win = -1;
        if (m_left[c] > 0) return 16'h0;
        if ((ZRC[c] != 0) && (a == 0)) return 16'h0;
        for (int i = 0; i < NWC[c]; i++)
            if (eff(c, i) && (int'(s_wa[c][i]) == a)) win = i;
        if ((BYC[c] != 0) && (win >= 0)) return s_wd[c][win] & MSK[c];
        return m_regs[c][a];
    endfunction

    task automatic model_update(int c);
        bit col = 0;
        if (s_init[c]) begin
            for (int a = 0; a < 16; a++) m_regs[c][a] = 16'h0;
            m_left[c]  = 0;
            m_conf[c]  = 1'b0;
            m_valid[c] = 1'b1;
        end else if (m_valid[c]) begin
            for (int i = 0; i < NWC[c]; i++)
                for (int k = i + 1; k < NWC[c]; k++)
                    if (eff(c, i) && eff(c, k) && (s_wa[c][i] == s_wa[c][k])) col = 1;
            if (m_left[c] > 0) begin
                m_regs[c][DEP[c] - m_left[c]] = 16'h0;
                m_left[c]--;
            end else begin
                for (int i = 0; i < NWC[c]; i++)
                    if (eff(c, i)) m_regs[c][s_wa[c][i]] = s_wd[c][i] & MSK[c];
                if (s_clr[c]) m_left[c] = DEP[c];
            end
            m_conf[c] = col;
        end
    endtask

    task automatic idle();
        for (int c = 0; c < NC; c++) begin
            s_init[c] = 1'b0;
            s_clr[c]  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                s_we[c][i] = 1'b0;
                s_wa[c][i] = 4'h0;
                s_wd[c][i] = 16'h0;
                s_ra[c][i] = 4'h0;
            end
        end
    endtask

    // Queue this cycle's expectations, advance the model at the edge, return with inputs idle.
    task automatic cyc();
        for (int c = 0; c < NC; c++) begin
            if (m_valid[c]) begin
                for (int j = 0; j < NRC[c]; j++)
                    sb.push_back('{c, 0, j, exp_read(c, int'(s_ra[c][j]))});
                sb.push_back('{c, 1, 0, 16'(m_left[c] > 0)});
                sb.push_back('{c, 2, 0, {15'b0, m_conf[c]}});
            end
        end
        @(posedge CLK);
        for (int c = 0; c < NC; c++) model_update(c);
        #1;
        idle();
    endtask

    always @(negedge CLK) begin
        while (sb.size() > 0) begin
            sb_t e;
            logic [15:0] act;
            e   = sb.pop_front();
            act = actual(e.cfg, e.kind, e.port);
            n_checks++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s cfg%0d port%0d at %0t: got %h expected %h",
                         kind_name(e.kind), e.cfg, e.port, $time, act, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < NC; c++) begin
            m_left[c]  = 0;
            m_conf[c]  = 1'b0;
            m_valid[c] = 1'b0;
            for (int a = 0; a < 16; a++) m_regs[c][a] = 16'h0;
        end
        idle();
        for (int c = 0; c < NC; c++) s_init[c] = 1'b1;
        cyc();
        for (int c = 0; c < NC; c++) s_init[c] = 1'b1;
        cyc();

        // simple write then read back; R0 write (dropped when R0 is hardwired)
        for (int c = 0; c < NC; c++) begin
            s_we[c][0] = 1'b1; s_wa[c][0] = 4'd3; s_wd[c][0] = 16'h005A; s_ra[c][0] = 4'd3;
        end
        cyc();
        for (int c = 0; c < NC; c++) s_ra[c][0] = 4'd3;
        cyc();
        for (int c = 0; c < NC; c++) begin
            s_we[c][0] = 1'b1; s_wa[c][0] = 4'd0; s_wd[c][0] = 16'h00FF; s_ra[c][0] = 4'd0;
        end
        cyc();
        for (int c = 0; c < NC; c++) s_ra[c][0] = 4'd0;
        cyc();

        // same-address collision, higher port wins
        for (int c = 0; c < NC; c++) begin
            s_we[c][0] = 1'b1; s_wa[c][0] = 4'd2; s_wd[c][0] = 16'h0011;
            s_we[c][1] = 1'b1; s_wa[c][1] = 4'd2; s_wd[c][1] = 16'h0022;
            s_ra[c][1] = 4'd2;
        end
        cyc();
        for (int c = 0; c < NC; c++) s_ra[c][1] = 4'd2;
        cyc();
        cyc();

        // bypass: old 0x10 overwritten by 0x77 while being read
        for (int c = 0; c < NC; c++) begin
            s_we[c][0] = 1'b1; s_wa[c][0] = 4'd5; s_wd[c][0] = 16'h0010;
        end
        cyc();
        for (int c = 0; c < NC; c++) begin
            s_we[c][0] = 1'b1; s_wa[c][0] = 4'd5; s_wd[c][0] = 16'h0077; s_ra[c][0] = 4'd5;
        end
        cyc();
        for (int c = 0; c < NC; c++) s_ra[c][0] = 4'd5;
        cyc();

        // fill, sweep with a lost mid-sweep write, then read everything back
        for (int k = 0; k < 16; k++) begin
            for (int c = 0; c < NC; c++)
                if (k < DEP[c]) begin
                    s_we[c][0] = 1'b1; s_wa[c][0] = 4'(k); s_wd[c][0] = 16'(k + 1);
                end
            cyc();
        end
        for (int c = 0; c < NC; c++) begin
            s_clr[c] = 1'b1; s_ra[c][0] = 4'd4;
        end
        cyc();
        for (int k = 0; k < 18; k++) begin
            for (int c = 0; c < NC; c++) begin
                for (int j = 0; j < 3; j++) s_ra[c][j] = 4'($urandom_range(0, DEP[c] - 1));
                if (k == 3) begin
                    s_we[c][0] = 1'b1; s_wa[c][0] = 4'd4; s_wd[c][0] = 16'h0099;
                end
                if (k == 5) s_clr[c] = 1'b1;
            end
            cyc();
        end
        for (int k = 0; k < 16; k++) begin
            for (int c = 0; c < NC; c++)
                for (int j = 0; j < 3; j++) s_ra[c][j] = 4'((k + j) % DEP[c]);
            cyc();
        end

        // init aborts a sweep; a following write lands normally
        for (int c = 0; c < NC; c++) begin
            s_we[c][0] = 1'b1; s_wa[c][0] = 4'd6; s_wd[c][0] = 16'h0066;
        end
        cyc();
        for (int c = 0; c < NC; c++) s_clr[c] = 1'b1;
        cyc();
        cyc();
        cyc();
        for (int c = 0; c < NC; c++) begin
            s_init[c] = 1'b1; s_we[c][0] = 1'b1; s_wa[c][0] = 4'd7; s_wd[c][0] = 16'h0044;
        end
        cyc();
        for (int c = 0; c < NC; c++) begin
            s_ra[c][0] = 4'd6; s_ra[c][1] = 4'd7;
        end
        cyc();
        for (int c = 0; c < NC; c++) begin
            s_we[c][0] = 1'b1; s_wa[c][0] = 4'd1; s_wd[c][0] = 16'h0033;
        end
        cyc();
        for (int c = 0; c < NC; c++) s_ra[c][0] = 4'd1;
        cyc();

        // wide config: top register on every read port
        s_we[2][0] = 1'b1; s_wa[2][0] = 4'd15; s_wd[2][0] = 16'hBEEF;
        cyc();
        for (int j = 0; j < 3; j++) s_ra[2][j] = 4'd15;
        cyc();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NC; c++) begin
                s_init[c] = ($urandom_range(0, 99) == 0);
                s_clr[c]  = ($urandom_range(0, 39) == 0);
                for (int i = 0; i < 4; i++) begin
                    s_we[c][i] = 1'($urandom_range(0, 1));
                    s_wa[c][i] = 4'($urandom_range(0, DEP[c] - 1));
                    s_wd[c][i] = 16'($urandom);
                    s_ra[c][i] = 4'($urandom_range(0, DEP[c] - 1));
                end
            end
            cyc();
        end

        cyc();
        @(negedge CLK);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
